// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants and helpers for the traffic-light countdown display.
package disp_scan_ctrl_pkg;

  // Scan slot index -> displayed digit
  localparam logic [1:0] DIGIT_A_TENS = 2'd0;
  localparam logic [1:0] DIGIT_A_ONES = 2'd1;
  localparam logic [1:0] DIGIT_B_TENS = 2'd2;
  localparam logic [1:0] DIGIT_B_ONES = 2'd3;

  // All anodes off (active-low)
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Largest count a two-digit display can show
  localparam logic [6:0] MAX_COUNT = 7'd99;

  // Radix used by the subtract-ten converter
  localparam logic [6:0] BCD_BASE = 7'd10;

  // Conversion FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CONV_A = 2'd1;
  localparam logic [1:0] ST_CONV_B = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  // Saturate an incoming count to what two digits can display
  function automatic logic [6:0] clamp_count(input logic [6:0] v);
    return (v > MAX_COUNT) ? MAX_COUNT : v;
  endfunction

  // One-hot-low anode pattern for a slot index
  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] an;
    an      = AN_OFF;
    an[idx] = 1'b0;
    return an;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_bin2bcd_seq.sv
// Sequential 7-bit to two-digit BCD converter: subtracts ten per cycle.
// A start pulse loads the operand; done_o is high in the cycle the
// remainder drops below ten, at which point tens_o/ones_o are valid and
// stay valid until the next start.
module bin2bcd_seq
  import disp_scan_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [6:0] bin_i,
  output logic       done_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  logic [6:0] rem_q, rem_d;
  logic [3:0] tens_q, tens_d;
  logic       run_q, run_d;

  assign done_o = run_q && (rem_q < BCD_BASE);
  assign tens_o = tens_q;
  assign ones_o = rem_q[3:0];

  // Next-state: load on start, otherwise one subtract step per cycle
  always_comb begin
    rem_d  = rem_q;
    tens_d = tens_q;
    run_d  = run_q;
    if (start_i) begin
      rem_d  = bin_i;
      tens_d = 4'd0;
      run_d  = 1'b1;
    end else if (run_q) begin
      if (rem_q >= BCD_BASE) begin
        rem_d  = rem_q - BCD_BASE;
        tens_d = tens_q + 4'd1;
      end else begin
        run_d = 1'b0;
      end
    end
  end

  // Converter state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= 7'd0;
      tens_q <= 4'd0;
      run_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      tens_q <= tens_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed display controller for two countdown values.
// Handshake: load is a single-cycle request accepted only while busy is
// low; busy rises the cycle after acceptance and falls once all four
// display digits have been written together. Loads seen while busy are
// dropped.
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] value_a,
  input  logic [6:0] value_b,
  input  logic       load,
  output logic       busy,
  input  logic       blank_lz,
  input  logic       blink_en,
  output logic [3:0] seg_bcd,
  output logic       seg_enable,
  output logic [3:0] digit_an
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // ---------------- conversion ----------------
  logic [1:0]       state_q, state_d;
  logic [6:0]       val_b_q, val_b_d;
  logic [3:0]       a_tens_q, a_tens_d;
  logic [3:0]       a_ones_q, a_ones_d;
  logic [3:0][3:0]  disp_q, disp_d;

  logic             conv_start;
  logic [6:0]       conv_bin;
  logic             conv_done;
  logic [3:0]       conv_tens;
  logic [3:0]       conv_ones;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (conv_start),
    .bin_i   (conv_bin),
    .done_o  (conv_done),
    .tens_o  (conv_tens),
    .ones_o  (conv_ones)
  );

  assign busy = (state_q != ST_IDLE);

  // Conversion FSM: A then B through the shared converter, then one-cycle commit
  always_comb begin
    state_d    = state_q;
    val_b_d    = val_b_q;
    a_tens_d   = a_tens_q;
    a_ones_d   = a_ones_q;
    disp_d     = disp_q;
    conv_start = 1'b0;
    conv_bin   = clamp_count(value_a);
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          conv_start = 1'b1;
          conv_bin   = clamp_count(value_a);
          val_b_d    = clamp_count(value_b);
          state_d    = ST_CONV_A;
        end
      end
      ST_CONV_A: begin
        if (conv_done) begin
          a_tens_d   = conv_tens;
          a_ones_d   = conv_ones;
          conv_start = 1'b1;
          conv_bin   = val_b_q;
          state_d    = ST_CONV_B;
        end
      end
      ST_CONV_B: begin
        if (conv_done) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // The converter holds B's result after done, so read it directly
        disp_d[DIGIT_A_TENS] = a_tens_q;
        disp_d[DIGIT_A_ONES] = a_ones_q;
        disp_d[DIGIT_B_TENS] = conv_tens;
        disp_d[DIGIT_B_ONES] = conv_ones;
        state_d              = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Conversion and display-digit registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      val_b_q  <= 7'd0;
      a_tens_q <= 4'd0;
      a_ones_q <= 4'd0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      val_b_q  <= val_b_d;
      a_tens_q <= a_tens_d;
      a_ones_q <= a_ones_d;
      disp_q   <= disp_d;
    end
  end

  // ---------------- scan ----------------
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_ph_q;
  logic [3:0]    seg_bcd_q;
  logic          seg_en_q;
  logic [3:0]    an_q;
  logic          tick;
  logic          frame_end;
  logic          lit;

  assign tick      = (presc_q == PW'(SCAN_DIV - 1));
  assign frame_end = tick && (idx_q == DIGIT_B_ONES);
  // Dark when blanking a zero tens digit, or in the off half of a blink
  assign lit       = !((blank_lz && !idx_q[0] && (disp_q[idx_q] == 4'd0)) ||
                       (blink_en && blink_ph_q));

  // Slot prescaler, wraps at SCAN_DIV-1
  always_ff @(posedge clk) begin
    if (!rst_n)    presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + PW'(1);
  end

  // Slot index and registered digit outputs, updated together on a tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q     <= DIGIT_A_TENS;
      seg_bcd_q <= 4'd0;
      seg_en_q  <= 1'b0;
      an_q      <= AN_OFF;
    end else if (tick) begin
      idx_q     <= idx_q + 2'd1;
      seg_bcd_q <= disp_q[idx_q];
      seg_en_q  <= lit;
      an_q      <= anode_for(idx_q);
    end
  end

  // Blink frame counter and phase; held clear while blinking is off
  always_ff @(posedge clk) begin
    if (!rst_n || !blink_en) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        blink_ph_q  <= ~blink_ph_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  assign seg_bcd    = seg_bcd_q;
  assign seg_enable = seg_en_q;
  assign digit_an   = an_q;

endmodule
